// File: rtl/nf10_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_axis_rr_arbiter
//
// Packet-granular round-robin arbiter. It shares one AXI4-Stream output
// between C_NUM_PORTS AXI4-Stream sources. A granted port keeps the output
// until its tlast beat is accepted. Arbitration then restarts one IDLE cycle
// later, searching from the port after the previous winner. No data is stored:
// the datapath is a combinational mux selected by the registered grant.
//
// Ports:
//   axi_aclk, axi_reset   clock, synchronous active-high reset
//   s_axis_t*             flattened slave streams, port i at slice [i*W +: W]
//   s_axis_tready         per-port ready (only the granted port can be ready)
//   m_axis_t*             shared master stream
//   m_axis_tready         downstream ready
//   grant_valid           high while a packet owns the output
//   grant_idx             owning port index (meaningful with grant_valid)
// -----------------------------------------------------------------------------
module nf10_axis_rr_arbiter #(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                             axi_aclk,
  input  logic                                             axi_reset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]       s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]        s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                           s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                           s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                           s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                     m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                   m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                    m_axis_tuser,
  output logic                                             m_axis_tvalid,
  output logic                                             m_axis_tlast,
  input  logic                                             m_axis_tready,
  output logic                                             grant_valid,
  output logic [2:0]                                       grant_idx
);

  localparam int N  = C_NUM_PORTS;
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  // Port 0 must have first priority after reset, so the "previous winner"
  // starts as the highest port.
  localparam logic [2:0] LAST_GRANT_RST = 3'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        grant, grant_nxt;
  logic [2:0]        last_grant, last_grant_nxt;

  logic              arb_found;
  logic [2:0]        arb_idx;
  int                cand;
  logic [N-1:0]      req_rot;

  logic              pass_en;
  logic [N*DW-1:0]   data_sh;
  logic [N*SW-1:0]   strb_sh;
  logic [N*UW-1:0]   user_sh;
  logic [N-1:0]      valid_sh;
  logic [N-1:0]      last_sh;

  // --- grant state registers ---
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_GRANT_RST;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Round-robin search: candidates last_grant+1 .. last_grant+N, wrapped.
  // Since last_grant < N and k <= N, one conditional subtract is enough.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    req_rot   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N) cand = cand - N;
      req_rot = s_axis_tvalid >> cand;
      if (!arb_found && req_rot[0]) begin
        arb_found = 1'b1;
        arb_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nxt = arb_idx;
          state_nxt = PASS;
        end
      end
      PASS: begin
        // Grant is held through source gaps; only an accepted tlast releases it.
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --- combinational output mux ---
  // Outputs are forced quiet while reset is asserted so nothing leaks out of a
  // truncated packet.
  assign pass_en = (state == PASS) && !axi_reset;

  always_comb begin
    data_sh  = s_axis_tdata  >> (int'(grant) * DW);
    strb_sh  = s_axis_tstrb  >> (int'(grant) * SW);
    user_sh  = s_axis_tuser  >> (int'(grant) * UW);
    valid_sh = s_axis_tvalid >> grant;
    last_sh  = s_axis_tlast  >> grant;

    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (pass_en) begin
      m_axis_tdata  = data_sh[DW-1:0];
      m_axis_tstrb  = strb_sh[SW-1:0];
      m_axis_tuser  = user_sh[UW-1:0];
      m_axis_tvalid = valid_sh[0];
      m_axis_tlast  = last_sh[0];
      s_axis_tready = {{(N-1){1'b0}}, m_axis_tready} << grant;
    end
  end

  assign grant_valid = pass_en;
  assign grant_idx   = axi_reset ? 3'b000 : grant;

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for nf10_axis_rr_arbiter (4 ports, 64-bit data, 128-bit tuser).
// Sources are packet queues per port. A reference model tracks ownership with
// the round-robin/packet rules and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_nf10_axis_rr_arbiter;

  localparam int N     = 4;
  localparam int W     = 64;
  localparam int SW    = 8;
  localparam int UW    = 128;
  localparam int OW    = 1 + 3 + N + 1 + 1 + W + SW + UW;
  localparam int DEPTH = 64;

  logic              axi_aclk = 1'b0;
  logic              axi_reset = 1'b1;
  logic [N*W-1:0]    s_axis_tdata = '0;
  logic [N*SW-1:0]   s_axis_tstrb = '0;
  logic [N*UW-1:0]   s_axis_tuser = '0;
  logic [N-1:0]      s_axis_tvalid = '0;
  logic [N-1:0]      s_axis_tlast = '0;
  logic [N-1:0]      s_axis_tready;
  logic [W-1:0]      m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              grant_valid;
  logic [2:0]        grant_idx;

  always #5 axi_aclk = ~axi_aclk;

  nf10_axis_rr_arbiter #(
    .C_NUM_PORTS(N), .C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  typedef struct packed {
    logic [UW-1:0] user;
    logic [SW-1:0] strb;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  beat_t     mem [N][DEPTH];
  int        head [N];
  int        tail [N];
  logic [N-1:0] gap = '0;
  logic      tready_drv = 1'b1;
  logic      rst = 1'b1;

  // reference model: owner of the output, previous winner
  bit        m_busy = 1'b0;
  int        m_owner = 0;
  int        m_last = N - 1;

  int        checks = 0;
  int        errors = 0;

  logic [OW-1:0] obs, exp;
  logic [W-1:0]  obs_data;
  logic          obs_tvalid, obs_tlast, obs_gv, hs_out;
  logic [N-1:0]  obs_tready;
  logic [2:0]    raw_gidx;
  logic          gv_q = 1'b0;
  int            dut_wins[$];

  task automatic clear_srcs();
    for (int p = 0; p < N; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    gap = '0;
  endtask

  task automatic push_pkt(input int p, input int len, input bit rnd);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt.data = rnd ? {$urandom, $urandom} : ((64'(p) << 56) | 64'(b + 1));
      bt.strb = rnd ? 8'($urandom) : 8'hFF;
      bt.user = rnd ? {$urandom, $urandom, $urandom, $urandom} : {96'd0, 32'(p * 16 + b)};
      bt.last = (b == len - 1);
      mem[p][tail[p] % DEPTH] = bt;
      tail[p]++;
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (head[p] != tail[p]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive sources at negedge, sample and predict, then move
  // sources and model across the rising edge.
  task automatic step();
    logic [N-1:0] vld;
    logic [N-1:0] rdy_seen;
    logic [N-1:0] r;
    @(negedge axi_aclk);
    s_axis_tvalid = '0; s_axis_tlast = '0;
    s_axis_tdata  = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    for (int p = 0; p < N; p++) begin
      if (head[p] != tail[p] && !gap[p]) begin
        beat_t bt;
        bt = mem[p][head[p] % DEPTH];
        s_axis_tvalid[p] = 1'b1;
        s_axis_tlast[p]  = bt.last;
        s_axis_tdata[p*W +: W]   = bt.data;
        s_axis_tstrb[p*SW +: SW] = bt.strb;
        s_axis_tuser[p*UW +: UW] = bt.user;
      end
    end
    m_axis_tready = tready_drv;
    axi_reset     = rst;
    #2;
    vld      = s_axis_tvalid;
    rdy_seen = s_axis_tready;
    exp = '0;
    if (m_busy && !rst) begin
      r = '0;
      r[m_owner] = tready_drv;
      exp = {1'b1, 3'(m_owner), r, s_axis_tvalid[m_owner], s_axis_tlast[m_owner],
             s_axis_tdata[m_owner*W +: W], s_axis_tstrb[m_owner*SW +: SW],
             s_axis_tuser[m_owner*UW +: UW]};
    end
    obs = {grant_valid, (m_busy && !rst) ? grant_idx : 3'b000, s_axis_tready,
           m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb, m_axis_tuser};
    obs_data   = m_axis_tdata;
    obs_tvalid = m_axis_tvalid;
    obs_tlast  = m_axis_tlast;
    obs_tready = s_axis_tready;
    obs_gv     = grant_valid;
    raw_gidx   = grant_idx;
    hs_out     = m_axis_tvalid && m_axis_tready;
    if (grant_valid && !gv_q) dut_wins.push_back(int'(grant_idx));
    gv_q = grant_valid;
    @(posedge axi_aclk);
    if (rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      if (vld != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (vld[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
      end
    end else if (vld[m_owner] && tready_drv) begin
      if (mem[m_owner][head[m_owner] % DEPTH].last) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
    for (int p = 0; p < N; p++) if (vld[p] && rdy_seen[p]) head[p]++;
  endtask

  task automatic apply_reset();
    clear_srcs();
    rst = 1'b1;
    tready_drv = 1'b1;
    step();
    step();
    rst = 1'b0;
    dut_wins.delete();
  endtask

  task automatic test_reset();
    clear_srcs();
    push_pkt(2, 2, 0);
    rst = 1'b1;
    tready_drv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_outputs c%0d: got %h want %h", c, obs, exp); end
      checks++;
      if (raw_gidx !== 3'd0) begin errors++; $display("FAIL reset_grant_idx c%0d: got %0d want 0", c, raw_gidx); end
    end
    rst = 1'b0;
    clear_srcs();
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL post_reset_outputs: got %h want %h", obs, exp); end
    checks++;
    if (raw_gidx !== 3'd0 || obs_gv !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant: got idx %0d gv %0b want 0 0", raw_gidx, obs_gv);
    end
  endtask

  task automatic test_single();
    int first = -1, nb = 0, lastc = -1;
    logic [W-1:0] first_data = '0;
    apply_reset();
    push_pkt(2, 4, 0);
    tready_drv = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single c%0d: got %h want %h", c, obs, exp); end
      if (hs_out) begin
        if (first < 0) begin first = c; first_data = obs_data; end
        nb++;
        if (obs_tlast) lastc = c;
      end
    end
    checks++;
    if (first != 1 || nb != 4 || lastc != 4) begin
      errors++; $display("FAIL single_timing: got first %0d beats %0d last %0d want 1 4 4", first, nb, lastc);
    end
    checks++;
    if (first_data !== 64'h0200_0000_0000_0001) begin
      errors++; $display("FAIL single_data: got %h want 0200000000000001", first_data);
    end
    checks++;
    if (dut_wins.size() != 1 || dut_wins[0] != 2) begin
      errors++; $display("FAIL single_grant: got %0d grants first %0d want 1 grant of port 2",
                         dut_wins.size(), dut_wins.size() > 0 ? dut_wins[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    int c = 0;
    apply_reset();
    for (int k = 0; k < 3; k++) for (int p = 0; p < N; p++) push_pkt(p, 2, 1);
    tready_drv = 1'b1;
    while (!all_empty() && c < 80) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rr c%0d: got %h want %h", c, obs, exp); end
      c++;
    end
    checks++;
    if (c != 36) begin errors++; $display("FAIL rr_cycles: got %0d want 36", c); end
    checks++;
    if (dut_wins.size() != 12) begin
      errors++; $display("FAIL rr_grant_count: got %0d want 12", dut_wins.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (dut_wins[i] != i % N) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, dut_wins[i], i % N);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d [9];
    int nb = 0, lastc = -1;
    apply_reset();
    push_pkt(1, 4, 1);
    for (int c = 0; c < 9; c++) begin
      tready_drv = (c % 2 == 1);
      step();
      d[c] = obs_data;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bp c%0d: got %h want %h", c, obs, exp); end
      if (hs_out) begin nb++; lastc = c; end
    end
    for (int c = 2; c < 8; c += 2) begin
      checks++;
      if (d[c] !== d[c+1]) begin errors++; $display("FAIL bp_stable c%0d: got %h want %h", c + 1, d[c+1], d[c]); end
    end
    checks++;
    if (nb != 4 || lastc != 7 || !all_empty()) begin
      errors++; $display("FAIL bp_done: got beats %0d last %0d want 4 7", nb, lastc);
    end
  endtask

  task automatic test_source_gap();
    int done_c = -1;
    apply_reset();
    push_pkt(1, 4, 1);
    tready_drv = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c == 1) push_pkt(0, 2, 1);
      gap = (c >= 3 && c <= 5) ? 4'b0010 : 4'b0000;
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL gap c%0d: got %h want %h", c, obs, exp); end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (obs_tvalid !== 1'b0 || obs_gv !== 1'b1 || raw_gidx !== 3'd1) begin
          errors++; $display("FAIL gap_hold c%0d: got tvalid %0b gv %0b idx %0d want 0 1 1",
                             c, obs_tvalid, obs_gv, raw_gidx);
        end
      end
      if (all_empty()) begin done_c = c; break; end
    end
    checks++;
    if (done_c != 10) begin errors++; $display("FAIL gap_done: got %0d want 10", done_c); end
    checks++;
    if (dut_wins.size() != 2 || dut_wins[0] != 1 || dut_wins[1] != 0) begin
      errors++; $display("FAIL gap_order: got %0d grants want 1 then 0", dut_wins.size());
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    apply_reset();
    push_pkt(3, 4, 1);
    tready_drv = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_during: got %h want %h", obs, exp); end
    rst = 1'b0;
    clear_srcs();
    step();
    checks++;
    if (obs_tvalid !== 1'b0 || obs_tready !== 4'b0000 || obs_gv !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: got tvalid %0b tready %b gv %0b want 0 0000 0",
                         obs_tvalid, obs_tready, obs_gv);
    end
    dut_wins.delete();
    push_pkt(0, 2, 1);
    push_pkt(3, 2, 1);
    while (!all_empty() && c < 20) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL rstmid c%0d: got %h want %h", c, obs, exp); end
      c++;
    end
    checks++;
    if (!all_empty() || dut_wins.size() != 2 || dut_wins[0] != 0 || dut_wins[1] != 3) begin
      errors++; $display("FAIL rstmid_order: got %0d grants first %0d want 0 then 3",
                         dut_wins.size(), dut_wins.size() > 0 ? dut_wins[0] : -1);
    end
  endtask

  task automatic test_wrap();
    int c = 0;
    apply_reset();
    push_pkt(3, 2, 1);
    tready_drv = 1'b1;
    while (!all_empty() && c < 25) begin
      if (c == 2) begin push_pkt(3, 2, 1); push_pkt(0, 2, 1); end
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap c%0d: got %h want %h", c, obs, exp); end
      c++;
    end
    checks++;
    if (c != 9) begin errors++; $display("FAIL wrap_cycles: got %0d want 9", c); end
    checks++;
    if (dut_wins.size() != 3 || dut_wins[0] != 3 || dut_wins[1] != 0 || dut_wins[2] != 3) begin
      errors++; $display("FAIL wrap_order: got %0d grants want 3,0,3", dut_wins.size());
    end
  endtask

  task automatic test_random();
    int c = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = int'($urandom_range(0, N - 1));
        if (tail[p] - head[p] < DEPTH - 8) push_pkt(p, int'($urandom_range(1, 5)), 1);
      end
      tready_drv = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < N; p++) gap[p] = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random c%0d: got %h want %h", i, obs, exp); end
    end
    gap = '0;
    tready_drv = 1'b1;
    while (!all_empty() && c < 400) begin
      step();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random_drain c%0d: got %h want %h", c, obs, exp); end
      c++;
    end
    checks++;
    if (!all_empty()) begin errors++; $display("FAIL random_drain_timeout: got queues pending want empty"); end
  endtask

  initial begin
    clear_srcs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_source_gap();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
